// File: rtl/stopwatch_pkg.sv
// Stopwatch shared definitions: FSM encoding,
// BCD digit limits and display field offsets.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } sw_state_t;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] LIM_9 = 4'd9;
  localparam logic [3:0] LIM_5 = 4'd5;

  localparam int OFS_CS_U  = 0;
  localparam int OFS_CS_T  = 4;
  localparam int OFS_SEC_U = 8;
  localparam int OFS_SEC_T = 12;
  localparam int OFS_MIN_U = 16;
  localparam int OFS_MIN_T = 20;

  function automatic logic [3:0] bcd_tens(int v);
    return 4'(v / 10);
  endfunction

  function automatic logic [3:0] bcd_units(int v);
    return 4'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit: counts 0..LIMIT on en, carry
// flags the terminal value so the next digit can ripple.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] LIMIT = LIM_9
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = (q == LIMIT);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= carry ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: button sync/edge detect, 100 Hz tick,
// six-digit BCD count, run/pause/lap FSM, registered display.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_MOD     = 60
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        clk_100hz,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [23:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        ovf
);

  localparam logic [3:0] MT_MAX = bcd_tens(MIN_MOD - 1);
  localparam logic [3:0] MU_MAX = bcd_units(MIN_MOD - 1);

  localparam logic [5:0][3:0] LIMS =
    {MT_MAX, LIM_9, LIM_5, LIM_9, LIM_9, LIM_9};

  logic [2:0]                  btn;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0]                  synced;
  logic [2:0]                  prev;
  logic [2:0]                  armed;
  logic [2:0]                  evt;
  logic [SYNC_STAGES:0]        fill;
  logic                        settled;

  logic ss_ev;
  logic clr_ev;
  logic lap_ev;

  assign btn = {btn_lap, btn_clear, btn_start_stop};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      synced[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign settled = fill[SYNC_STAGES];

  // A button only arms once seen low after the chain has
  // flushed, so one held through reset never fires.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev   <= '0;
      armed  <= '0;
      fill   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn[i]};
      end
      prev  <= synced;
      armed <= armed | (~synced & {3{settled}});
      fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign evt    = synced & ~prev & armed;
  assign ss_ev  = evt[0];
  assign clr_ev = evt[1];
  assign lap_ev = evt[2];

  logic [1:0] hz_q;
  logic       tick;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      hz_q <= '0;
    end else begin
      hz_q <= {hz_q[0], clk_100hz};
    end
  end

  assign tick = hz_q[0] & ~hz_q[1];

  sw_state_t state;
  sw_state_t state_nxt;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr_ev) begin
      state_nxt = S_IDLE;
    end else if (ss_ev) begin
      unique case (state)
        S_IDLE:  state_nxt = S_RUN;
        S_RUN:   state_nxt = S_PAUSE;
        S_PAUSE: state_nxt = S_RUN;
        S_LAP:   state_nxt = S_PAUSE;
        default: state_nxt = S_IDLE;
      endcase
    end else if (lap_ev) begin
      unique case (state)
        S_RUN:   state_nxt = S_LAP;
        S_LAP:   state_nxt = S_RUN;
        default: state_nxt = state;
      endcase
    end
  end

  logic            count_en;
  logic [5:0]      en;
  logic [5:0]      tc;
  logic [5:0]      clr_v;
  logic [5:0][3:0] dig;
  logic            min_max;
  logic            wrap;

  assign count_en = tick & (state == S_RUN || state == S_LAP);

  assign en[0] = count_en;
  assign en[1] = en[0] & tc[0];
  assign en[2] = en[1] & tc[1];
  assign en[3] = en[2] & tc[2];
  assign en[4] = en[3] & tc[3];
  assign en[5] = en[4] & tc[4];

  // Minutes wrap on the modulus, not on the digit limits.
  assign min_max = tc[5] & (dig[4] == MU_MAX);
  assign wrap    = en[4] & min_max;

  assign clr_v = {{2{clr_ev | wrap}}, {4{clr_ev}}};

  for (genvar g = 0; g < 6; g++) begin : g_dig
    bcd_digit_cnt #(
      .LIMIT (LIMS[g])
    ) u_dig (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en[g]),
      .clr    (clr_v[g]),
      .q      (dig[g]),
      .carry  (tc[g])
    );
  end

  logic [23:0] live;

  always_comb begin
    live = '0;
    live[OFS_CS_U  +: DIGIT_W] = dig[0];
    live[OFS_CS_T  +: DIGIT_W] = dig[1];
    live[OFS_SEC_U +: DIGIT_W] = dig[2];
    live[OFS_SEC_T +: DIGIT_W] = dig[3];
    live[OFS_MIN_U +: DIGIT_W] = dig[4];
    live[OFS_MIN_T +: DIGIT_W] = dig[5];
  end

  logic        enter_lap;
  logic        cap;
  logic [23:0] snap;

  assign enter_lap = (state == S_RUN) && (state_nxt == S_LAP);

  // Snapshot is taken the cycle after the lap event so it
  // includes a tick that landed in the same cycle.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cap  <= 1'b0;
      snap <= '0;
      ovf  <= 1'b0;
      disp <= '0;
    end else begin
      cap <= enter_lap;
      if (clr_ev) begin
        snap <= '0;
      end else if (cap) begin
        snap <= live;
      end
      if (clr_ev) begin
        ovf <= 1'b0;
      end else if (wrap) begin
        ovf <= 1'b1;
      end
      if (cap || state != S_LAP) begin
        disp <= live;
      end else begin
        disp <= snap;
      end
    end
  end

  assign running    = (state == S_RUN) || (state == S_LAP);
  assign lap_active = (state == S_LAP);

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomized bench for stopwatch_core against a
// centisecond-integer reference model.
module tb_stopwatch_core;

  localparam int SYNC = 2;
  localparam int MM   = 2;
  localparam int MAXC = MM * 6000;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        clk_100hz = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_lap = 1'b0;
  logic [23:0] disp;
  logic        running;
  logic        lap_active;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_core #(
    .SYNC_STAGES (SYNC),
    .MIN_MOD     (MM)
  ) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .clk_100hz      (clk_100hz),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .disp           (disp),
    .running        (running),
    .lap_active     (lap_active),
    .ovf            (ovf)
  );

  always #5 clk_in = ~clk_in;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_e;

  mstate_e m_st   = M_IDLE;
  int      m_cnt  = 0;
  int      m_snap = 0;
  bit      m_ovf  = 1'b0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(int c);
    int m  = c / 6000;
    int s  = (c / 100) % 60;
    int cs = c % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10),
            4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic void m_tick();
    if (m_st == M_RUN || m_st == M_LAP) begin
      m_cnt++;
      if (m_cnt == MAXC) begin
        m_cnt = 0;
        m_ovf = 1'b1;
      end
    end
  endfunction

  function automatic void m_buttons(bit ss, bit cl, bit lp);
    if (cl) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      m_st  = M_IDLE;
    end else if (ss) begin
      case (m_st)
        M_IDLE:  m_st = M_RUN;
        M_RUN:   m_st = M_PAUSE;
        M_PAUSE: m_st = M_RUN;
        M_LAP:   m_st = M_PAUSE;
        default: m_st = M_IDLE;
      endcase
    end else if (lp) begin
      if (m_st == M_RUN) begin
        m_st   = M_LAP;
        m_snap = m_cnt;
      end else if (m_st == M_LAP) begin
        m_st = M_RUN;
      end
    end
  endfunction

  task automatic check_all(string tag);
    logic [23:0] exp_d;
    exp_d = (m_st == M_LAP) ? to_bcd(m_snap) : to_bcd(m_cnt);
    check({tag, "_disp"}, disp, exp_d);
    check({tag, "_run"}, running,
          (m_st == M_RUN || m_st == M_LAP));
    check({tag, "_lap"}, lap_active, (m_st == M_LAP));
    check({tag, "_ovf"}, ovf, m_ovf);
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      @(negedge clk_in);
      clk_100hz = 1'b1;
      m_tick();
      @(negedge clk_in);
      clk_100hz = 1'b0;
    end
    repeat (3) @(negedge clk_in);
  endtask

  // wt lines the clk_100hz edge up so the tick lands in
  // the same cycle as the button event.
  task automatic press(bit ss, bit cl, bit lp, bit wt);
    @(negedge clk_in);
    btn_start_stop = ss;
    btn_clear      = cl;
    btn_lap        = lp;
    if (wt) begin
      repeat (SYNC - 1) @(negedge clk_in);
      clk_100hz = 1'b1;
      m_tick();
    end
    m_buttons(ss, cl, lp);
    repeat (SYNC + 3) @(negedge clk_in);
    clk_100hz      = 1'b0;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    btn_lap        = 1'b0;
    repeat (SYNC + 3) @(negedge clk_in);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_disp", disp, 24'h0);
    check("rst_run", running, 1'b0);
    check("rst_lap", lap_active, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b1;
    repeat (10) @(negedge clk_in);
    check_all("post_rst");

    press(1, 0, 0, 0);
    ticks(150);
    check("run150", disp, 24'h000150);
    check("run150_run", running, 1'b1);
    check_all("run150");

    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    ticks(1234);
    check("pre_lap", disp, 24'h001234);
    press(0, 0, 1, 0);
    ticks(100);
    check("lap_hold", disp, 24'h001234);
    check("lap_act", lap_active, 1'b1);
    press(0, 0, 1, 0);
    check("lap_exit", disp, 24'h001334);
    check_all("lap_exit");

    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    ticks(500);
    check("pre_clr", disp, 24'h000500);
    press(1, 1, 0, 0);
    check("clr_ss_disp", disp, 24'h0);
    check("clr_ss_run", running, 1'b0);
    check_all("clr_ss");

    press(1, 0, 0, 0);
    ticks(5999);
    check("at_5999", disp, 24'h005999);
    ticks(1);
    check("min_carry", disp, 24'h010000);
    ticks(5999);
    check("at_max", disp, 24'h015999);
    check("at_max_ovf", ovf, 1'b0);
    ticks(1);
    check("wrap_disp", disp, 24'h000000);
    check("wrap_ovf", ovf, 1'b1);
    check("wrap_run", running, 1'b1);
    ticks(5);
    check_all("post_wrap");
    press(0, 1, 0, 0);
    check("clr_ovf", ovf, 1'b0);

    press(1, 0, 0, 0);
    ticks(10);
    press(1, 0, 0, 1);
    check("ss_tick_disp", disp, 24'h000011);
    check("ss_tick_run", running, 1'b0);
    press(0, 0, 1, 0);
    check("pause_lap_ign", lap_active, 1'b0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 1);
    ticks(20);
    check("lap_tick_snap", disp, 24'h000012);
    check_all("lap_tick");
    press(0, 0, 1, 0);
    check_all("lap_tick_exit");

    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    ticks(321);
    check("pre_rst", disp, 24'h000321);
    @(negedge clk_in);
    btn_start_stop = 1'b1;
    clk_100hz      = 1'b1;
    @(posedge clk_in);
    #2 rst = 1'b0;
    #1;
    check("arst_disp", disp, 24'h0);
    check("arst_run", running, 1'b0);
    check("arst_lap", lap_active, 1'b0);
    check("arst_ovf", ovf, 1'b0);
    m_st  = M_IDLE;
    m_cnt = 0;
    m_ovf = 1'b0;
    @(negedge clk_in);
    clk_100hz = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    repeat (20) @(negedge clk_in);
    check("held_btn", running, 1'b0);
    check_all("held_btn");
    btn_start_stop = 1'b0;
    repeat (6) @(negedge clk_in);
    press(1, 0, 0, 0);
    check("repress", running, 1'b1);

    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        ticks($urandom_range(1, 200));
      end else if (r <= 5) begin
        press(1, 0, 0, $urandom_range(0, 1) == 1);
      end else if (r <= 7) begin
        press(0, 0, 1, $urandom_range(0, 1) == 1);
      end else if (r == 8) begin
        press(0, 1, 0, $urandom_range(0, 1) == 1);
      end else if ($urandom_range(0, 1) == 1) begin
        press(1, 0, 1, 0);
      end else begin
        press(0, 1, 1, 0);
      end
      check_all($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
